mult_div_unit: RTL and testbench

- Multicycle multiply/divide responder for the MIPS-subset datapath, driven by the control unit's `start`/`MDControl` request.
- Performs signed 32x32 MULT (radix-2 Booth) or signed 32/32 DIV (restoring division on magnitudes).
- Writes the result into architectural `Hi`/`Lo` registers and answers with a one-cycle `done`, or with `divZero` for division by zero.
- `Hi`/`Lo` feed the `DataSrc` mux for MFHI/MFLO.

---
 rtl/uc_pkg.sv | 23 ++
 rtl/hilo_regs.sv | 32 +++
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared control-unit definitions: MDControl encoding, mult/div FSM states and datapath width.
package uc_pkg;

  localparam int WIDTH = 32;

  localparam logic MD_MULT = 1'b0;
  localparam logic MD_DIV  = 1'b1;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_MRUN_ENC   = 3'd1;
  localparam logic [2:0] ST_DRUN_ENC   = 3'd2;
  localparam logic [2:0] ST_FINISH_ENC = 3'd3;
  localparam logic [2:0] ST_DZERO_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_MRUN   = ST_MRUN_ENC,
    ST_DRUN   = ST_DRUN_ENC,
    ST_FINISH = ST_FINISH_ENC,
    ST_DZERO  = ST_DZERO_ENC
  } md_state_t;

endpackage

// File: rtl/hilo_regs.sv
// Architectural Hi/Lo registers: one write enable loads both halves from a double-width word.
module hilo_regs #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [WIDTH-1:0] half_reg [2];

  // Index 1 holds the upper half (Hi), index 0 the lower half (Lo).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      always_ff @(posedge clk) begin
        if (reset) begin
          half_reg[gi] <= '0;
        end else if (we) begin
          half_reg[gi] <= wdata[gi*WIDTH +: WIDTH];
        end
      end
    end
  endgenerate

  assign hi = half_reg[1];
  assign lo = half_reg[0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) responder.
// Result lands in Hi/Lo 34 cycles after the start request, with a one-cycle done.
module mult_div_unit #(
  parameter int WIDTH = uc_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MDControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  import uc_pkg::*;

  md_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] acc_reg;    // Booth accumulator / division remainder
  logic [WIDTH-1:0] mq_reg;     // multiplier / quotient
  logic [WIDTH-1:0] opnd_reg;   // multiplicand / divisor magnitude
  logic             q_reg;      // Booth q-1 bit
  logic             op_reg;
  logic             sign_a_reg;
  logic             sign_q_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dz_reg;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [2*WIDTH-1:0] hilo_wdata;
  logic             hilo_we;
  logic             last_step;

  always_comb begin
    abs_a = A[WIDTH-1] ? -A : A;
    abs_b = B[WIDTH-1] ? -B : B;
  end

  // Booth step on a sign-extended accumulator so that subtracting the most
  // negative multiplicand cannot overflow before the shift.
  always_comb begin
    booth_sum = {acc_reg[WIDTH-1], acc_reg};
    case ({mq_reg[0], q_reg})
      2'b01:   booth_sum = {acc_reg[WIDTH-1], acc_reg} + {opnd_reg[WIDTH-1], opnd_reg};
      2'b10:   booth_sum = {acc_reg[WIDTH-1], acc_reg} - {opnd_reg[WIDTH-1], opnd_reg};
      default: booth_sum = {acc_reg[WIDTH-1], acc_reg};
    endcase
  end

  // Restoring step: the remainder stays below the divisor, so the shifted
  // value fits WIDTH+1 bits and trial[WIDTH] is a reliable sign.
  always_comb begin
    rem_sh = {acc_reg, mq_reg[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd_reg};
  end

  always_comb begin
    rem_fix    = sign_a_reg ? -acc_reg : acc_reg;
    quo_fix    = sign_q_reg ? -mq_reg : mq_reg;
    hilo_wdata = (op_reg == MD_DIV) ? {rem_fix, quo_fix} : {acc_reg, mq_reg};
    hilo_we    = (state_reg == ST_FINISH);
    last_step  = (cnt_reg == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mq_reg     <= '0;
      opnd_reg   <= '0;
      q_reg      <= 1'b0;
      op_reg     <= MD_MULT;
      sign_a_reg <= 1'b0;
      sign_q_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      dz_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cnt_reg  <= '0;
            acc_reg  <= '0;
            q_reg    <= 1'b0;
            op_reg   <= MDControl;
            busy_reg <= 1'b1;
            if (MDControl == MD_MULT) begin
              opnd_reg  <= A;
              mq_reg    <= B;
              state_reg <= ST_MRUN;
            end else if (B != '0) begin
              opnd_reg   <= abs_b;
              mq_reg     <= abs_a;
              sign_a_reg <= A[WIDTH-1];
              sign_q_reg <= A[WIDTH-1] ^ B[WIDTH-1];
              state_reg  <= ST_DRUN;
            end else begin
              state_reg <= ST_DZERO;
            end
          end
        end
        ST_MRUN: begin
          acc_reg <= booth_sum[WIDTH:1];
          mq_reg  <= {booth_sum[0], mq_reg[WIDTH-1:1]};
          q_reg   <= mq_reg[0];
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) state_reg <= ST_FINISH;
        end
        ST_DRUN: begin
          if (!trial[WIDTH]) begin
            acc_reg <= trial[WIDTH-1:0];
            mq_reg  <= {mq_reg[WIDTH-2:0], 1'b1};
          end else begin
            acc_reg <= rem_sh[WIDTH-1:0];
            mq_reg  <= {mq_reg[WIDTH-2:0], 1'b0};
          end
          cnt_reg <= cnt_reg + 1'b1;
          if (last_step) state_reg <= ST_FINISH;
        end
        ST_FINISH: begin
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        ST_DZERO: begin
          dz_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  hilo_regs #(.WIDTH(WIDTH)) u_hilo (
    .clk   (clk),
    .reset (reset),
    .we    (hilo_we),
    .wdata (hilo_wdata),
    .hi    (Hi),
    .lo    (Lo)
  );

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign divZero = dz_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected results, monitor checks done/divZero.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        MDControl = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, divZero;
  logic [31:0] Hi, Lo;

  mult_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDControl (MDControl),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .done      (done),
    .divZero   (divZero),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          dz;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          busy_cnt = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: plain 64-bit signed arithmetic, truncating division.
  function automatic void model(input bit div, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!div) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Called at the negedge where start is presented; capture happens at edge cyc+1.
  task automatic push_exp(input bit div, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (div && b == 32'd0) begin
      e.dz = 1'b1; e.hi = last_hi; e.lo = last_lo; e.cyc = cyc + 2;
    end else begin
      e.dz = 1'b0;
      model(div, a, b, e.hi, e.lo);
      e.cyc = cyc + 34;
      last_hi = e.hi;
      last_lo = e.lo;
    end
    exp_q.push_back(e);
  endtask

  task automatic issue(input bit div, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; MDControl = div; A = a; B = b;
    push_exp(div, a, b);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; MDControl = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: compares every done/divZero against the scoreboard head.
  always @(posedge clk) begin
    #1;
    if (reset) busy_cnt = 0;
    else if (busy) busy_cnt++;
    if (done || divZero) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got done=%0d divZero=%0d required none", done, divZero);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn %s cycle=%0d Hi=%h Lo=%h", done ? "done" : "divZero", cyc, Hi, Lo);
        chk("kind_dz", {31'd0, divZero}, {31'd0, e.dz});
        chk("kind_done", {31'd0, done}, {31'd0, !e.dz});
        chk("latency", cyc, e.cyc);
        chk("Hi", Hi, e.hi);
        chk("Lo", Lo, e.lo);
        chk("busy_low", {31'd0, busy}, 32'd0);
        if (done) chk("busy_cycles", busy_cnt, 33);
      end
      busy_cnt = 0;
    end
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_response: got nothing by cycle %0d required at %0d", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_divZero", {31'd0, divZero}, 32'd0);
    chk("rst_Hi", Hi, 32'd0);
    chk("rst_Lo", Lo, 32'd0);

    issue(1'b0, 32'd7, 32'hFFFFFFFD);        wait_idle();
    issue(1'b1, 32'hFFFFFFEF, 32'd5);        wait_idle();
    issue(1'b1, 32'd17, 32'hFFFFFFFB);       wait_idle();
    issue(1'b1, 32'd100, 32'd0);             wait_idle();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    issue(1'b0, 32'h80000000, 32'h80000000); wait_idle();
    issue(1'b1, 32'h80000000, 32'd1);        wait_idle();

    // Abandoned operation: ignored re-start, then reset mid-flight.
    @(negedge clk);
    start = 1'b1; MDControl = 1'b0; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start = 1'b1; A = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_Hi", Hi, 32'd0);
    chk("midrst_Lo", Lo, 32'd0);
    last_hi = '0;
    last_lo = '0;
    repeat (40) @(negedge clk);
    issue(1'b0, 32'd3, 32'd4);
    wait_idle();

    // start held high: each op captured the edge after the previous done.
    begin
      logic [31:0] ha [3];
      logic [31:0] hb [3];
      bit          hd [3];
      for (int i = 0; i < 3; i++) begin
        ha[i] = $urandom;
        hb[i] = $urandom | 32'd1;
        hd[i] = (i == 1);
      end
      @(negedge clk);
      start = 1'b1; MDControl = hd[0]; A = ha[0]; B = hb[0];
      push_exp(hd[0], ha[0], hb[0]);
      for (int i = 0; i < 3; i++) begin
        for (int j = 1; j <= 34; j++) begin
          @(negedge clk);
          if (i == 2 && j == 1) begin
            start = 1'b0;
            break;
          end
          if (j == 34) begin
            MDControl = hd[i+1]; A = ha[i+1]; B = hb[i+1];
            push_exp(hd[i+1], ha[i+1], hb[i+1]);
          end else begin
            MDControl = $urandom_range(0, 1); A = $urandom; B = $urandom;
          end
        end
      end
      wait_idle();
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      bit          d;
      d = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = $urandom_range(0, 255); b = $urandom_range(1, 15); end
        2: a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0};
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      issue(d, a, b);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
